mem_port_arbiter: RTL and testbench



---
 rtl/mem_pkg.sv | 33 +++
 rtl/mem_port_arbiter_if.sv | 59 +++++
 rtl/arb_grant_logic.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared widths, owner encoding and helpers for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package mem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_DMA  = 2'b10
    } owner_e;

    // Saturating increment; the caller truncates to its counter width.
    function automatic int unsigned sat_inc(input int unsigned value,
                                            input int unsigned max_value);
        int unsigned result;
        result = value;
        if (value < max_value) begin
            result = value + 1;
        end
        return result;
    endfunction

endpackage : mem_pkg

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Both requester ports plus the blockram port of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface mem_port_arbiter_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    // Requesters and blockram side.
    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );

endinterface : mem_port_arbiter_if

`default_nettype wire

// File: rtl/arb_grant_logic.sv
// ============================================================================
// Module   : arb_grant_logic
// Purpose  : Combinational grant choice with owner stickiness and burst limit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module arb_grant_logic
    import mem_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic             c_req_i,
    input  logic             d_req_i,
    input  owner_e           owner_i,
    input  logic [CNT_W-1:0] burst_cnt_i,
    output logic             c_gnt_o,
    output logic             d_gnt_o
);

    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    logic burst_done_w;

    assign burst_done_w = (burst_cnt_i >= BURST_LIMIT);

    always_comb begin
        c_gnt_o = 1'b0;
        d_gnt_o = 1'b0;
        unique case ({c_req_i, d_req_i})
            2'b10: c_gnt_o = 1'b1;
            2'b01: d_gnt_o = 1'b1;
            2'b11: begin
                // Contention: the owner keeps the port until its burst is spent.
                unique case (owner_i)
                    OWN_CPU: begin
                        c_gnt_o = ~burst_done_w;
                        d_gnt_o =  burst_done_w;
                    end
                    OWN_DMA: begin
                        d_gnt_o = ~burst_done_w;
                        c_gnt_o =  burst_done_w;
                    end
                    default: c_gnt_o = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule : arb_grant_logic

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one blockram data port between CPU and DMA requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    owner_e            owner_q, owner_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic              rd_pend_c_q, rd_pend_c_d;
    logic              rd_pend_d_q, rd_pend_d_d;

    logic              c_gnt_raw_w, d_gnt_raw_w;
    logic              c_gnt_w, d_gnt_w;
    logic [ADDR_W-1:0] mem_addr_w;
    logic [DATA_W-1:0] mem_wdata_w;
    logic              mem_we_w;

    arb_grant_logic #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_grant (
        .c_req_i     (bus.c_req),
        .d_req_i     (bus.d_req),
        .owner_i     (owner_q),
        .burst_cnt_i (burst_cnt_q),
        .c_gnt_o     (c_gnt_raw_w),
        .d_gnt_o     (d_gnt_raw_w)
    );

    // Reset blocks grants combinationally so nothing reaches the blockram.
    assign c_gnt_w = c_gnt_raw_w & ~reset;
    assign d_gnt_w = d_gnt_raw_w & ~reset;

    always_comb begin
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        if (c_gnt_w) begin
            if (owner_q == OWN_CPU) begin
                burst_cnt_d = CNT_W'(sat_inc(32'(burst_cnt_q), CNT_MAX));
            end else begin
                owner_d     = OWN_CPU;
                burst_cnt_d = CNT_W'(1);
            end
        end else if (d_gnt_w) begin
            if (owner_q == OWN_DMA) begin
                burst_cnt_d = CNT_W'(sat_inc(32'(burst_cnt_q), CNT_MAX));
            end else begin
                owner_d     = OWN_DMA;
                burst_cnt_d = CNT_W'(1);
            end
        end else begin
            owner_d     = OWN_NONE;
            burst_cnt_d = '0;
        end
        rd_pend_c_d = c_gnt_w & ~bus.c_we;
        rd_pend_d_d = d_gnt_w & ~bus.d_we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q     <= OWN_NONE;
            burst_cnt_q <= '0;
            rd_pend_c_q <= 1'b0;
            rd_pend_d_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pend_c_q <= rd_pend_c_d;
            rd_pend_d_q <= rd_pend_d_d;
        end
    end

    always_comb begin
        mem_addr_w  = '0;
        mem_wdata_w = '0;
        mem_we_w    = 1'b0;
        if (c_gnt_w) begin
            mem_addr_w  = bus.c_addr;
            mem_wdata_w = bus.c_wdata;
            mem_we_w    = bus.c_we;
        end else if (d_gnt_w) begin
            mem_addr_w  = bus.d_addr;
            mem_wdata_w = bus.d_wdata;
            mem_we_w    = bus.d_we;
        end
    end

    assign bus.c_gnt     = c_gnt_w;
    assign bus.d_gnt     = d_gnt_w;
    assign bus.mem_addr  = mem_addr_w;
    assign bus.mem_wdata = mem_wdata_w;
    assign bus.mem_we    = mem_we_w;

    // Both requesters see the raw blockram output; rvalid selects the owner.
    assign bus.c_rvalid  = rd_pend_c_q;
    assign bus.d_rvalid  = rd_pend_d_q;
    assign bus.c_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;

endmodule : mem_port_arbiter

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter with a blockram model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_port_arbiter #(
        .ADDR_W    (16),
        .DATA_W    (16),
        .MAX_BURST (4),
        .CNT_W     (3)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    // Read-first synchronous blockram.
    logic [15:0] mem [0:65535];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    typedef struct {
        logic        rst;
        logic        cr;
        logic        cw;
        logic [15:0] ca;
        logic [15:0] cd;
        logic        dr;
        logic        dw;
        logic [15:0] da;
        logic [15:0] dd;
        logic        e_cg;
        logic        e_dg;
        logic        e_we;
        logic [15:0] e_addr;
        logic        e_cv;
        logic        e_dv;
        logic [15:0] e_rd;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic cr, input logic cw, input logic [15:0] ca,
                         input logic [15:0] cd, input logic dr, input logic dw,
                         input logic [15:0] da, input logic [15:0] dd);
        rst         = r;
        bus.c_req   = cr;
        bus.c_we    = cw;
        bus.c_addr  = ca;
        bus.c_wdata = cd;
        bus.d_req   = dr;
        bus.d_we    = dw;
        bus.d_addr  = da;
        bus.d_wdata = dd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0010] = 16'hBEEF;
        mem[16'h0020] = 16'h2222;
        mem[16'h0200] = 16'h5555;
        bus.mem_rdata = 16'h0000;

        //          rst cr cw ca       cd       dr dw da       dd       cg dg we addr     cv dv rd
        vecs[0]  = '{1, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0020, 16'h0, 0, 0, 0, 16'h0000, 0, 0, 16'h0};
        vecs[1]  = '{1, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0020, 16'h0, 0, 0, 0, 16'h0000, 0, 0, 16'h0};
        vecs[2]  = '{1, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0020, 16'h0, 0, 0, 0, 16'h0000, 0, 0, 16'h0};
        vecs[3]  = '{0, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0020, 16'h0, 1, 0, 0, 16'h0010, 0, 0, 16'h0};
        vecs[4]  = '{0, 0, 0, 16'h0000, 16'h0, 1, 0, 16'h0020, 16'h0, 0, 1, 0, 16'h0020, 1, 0, 16'hBEEF};
        vecs[5]  = '{0, 0, 0, 16'h0000, 16'h0, 0, 0, 16'h0000, 16'h0, 0, 0, 0, 16'h0000, 0, 1, 16'h2222};
        vecs[6]  = '{0, 1, 0, 16'h0200, 16'h0, 1, 1, 16'h0200, 16'h1234, 1, 0, 0, 16'h0200, 0, 0, 16'h0};
        vecs[7]  = '{0, 0, 0, 16'h0000, 16'h0, 1, 1, 16'h0200, 16'h1234, 0, 1, 1, 16'h0200, 1, 0, 16'h5555};
        vecs[8]  = '{0, 1, 0, 16'h0200, 16'h0, 0, 0, 16'h0000, 16'h0, 1, 0, 0, 16'h0200, 0, 0, 16'h0};
        vecs[9]  = '{0, 0, 0, 16'h0000, 16'h0, 0, 0, 16'h0000, 16'h0, 0, 0, 0, 16'h0000, 1, 0, 16'h1234};
        vecs[10] = '{0, 0, 0, 16'h0000, 16'h0, 1, 0, 16'h0010, 16'h0, 0, 1, 0, 16'h0010, 0, 0, 16'h0};
        vecs[11] = '{0, 0, 0, 16'h0000, 16'h0, 0, 0, 16'h0000, 16'h0, 0, 0, 0, 16'h0000, 0, 1, 16'hBEEF};
        vecs[12] = '{0, 1, 1, 16'h0030, 16'hA5A5, 0, 0, 16'h0000, 16'h0, 1, 0, 1, 16'h0030, 0, 0, 16'h0};
        vecs[13] = '{0, 1, 0, 16'h0030, 16'h0, 0, 0, 16'h0000, 16'h0, 1, 0, 0, 16'h0030, 0, 0, 16'h0};
        vecs[14] = '{0, 0, 0, 16'h0000, 16'h0, 0, 0, 16'h0000, 16'h0, 0, 0, 0, 16'h0000, 1, 0, 16'hA5A5};
        vecs[15] = '{0, 0, 0, 16'h0000, 16'h0, 1, 0, 16'h0010, 16'h0, 0, 1, 0, 16'h0010, 0, 0, 16'h0};
        vecs[16] = '{1, 0, 0, 16'h0000, 16'h0, 1, 0, 16'h0010, 16'h0, 0, 0, 0, 16'h0000, 0, 1, 16'hBEEF};
        vecs[17] = '{0, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0020, 16'h0, 1, 0, 0, 16'h0010, 0, 0, 16'h0};
        vecs[18] = '{0, 0, 0, 16'h0000, 16'h0, 0, 0, 16'h0000, 16'h0, 0, 0, 0, 16'h0000, 1, 0, 16'hBEEF};

        drive(1, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
                  vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dd);
            #1;
            check($sformatf("v%0d c_gnt", i), 32'(bus.c_gnt), 32'(vecs[i].e_cg));
            check($sformatf("v%0d d_gnt", i), 32'(bus.d_gnt), 32'(vecs[i].e_dg));
            check($sformatf("v%0d mem_we", i), 32'(bus.mem_we), 32'(vecs[i].e_we));
            check($sformatf("v%0d mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].e_addr));
            check($sformatf("v%0d c_rvalid", i), 32'(bus.c_rvalid), 32'(vecs[i].e_cv));
            check($sformatf("v%0d d_rvalid", i), 32'(bus.d_rvalid), 32'(vecs[i].e_dv));
            if (vecs[i].e_cv) check($sformatf("v%0d c_rdata", i), 32'(bus.c_rdata), 32'(vecs[i].e_rd));
            if (vecs[i].e_dv) check($sformatf("v%0d d_rdata", i), 32'(bus.d_rdata), 32'(vecs[i].e_rd));
        end

        // Continuous contention from idle: blocks of four, CPU first.
        @(negedge clk);
        drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        begin
            logic prev_c;
            prev_c = 1'b0;
            for (int i = 0; i < 20; i++) begin
                logic exp_c;
                exp_c = ((i / 4) % 2) == 0;
                @(negedge clk);
                drive(0, 1, 0, 16'h0040, 16'h0, 1, 0, 16'h0050, 16'h0);
                #1;
                check($sformatf("burst%0d c_gnt", i), 32'(bus.c_gnt), 32'(exp_c));
                check($sformatf("burst%0d d_gnt", i), 32'(bus.d_gnt), 32'(!exp_c));
                check($sformatf("burst%0d mem_addr", i), 32'(bus.mem_addr),
                      exp_c ? 32'h0040 : 32'h0050);
                if (i > 0) begin
                    check($sformatf("burst%0d c_rvalid", i), 32'(bus.c_rvalid), 32'(prev_c));
                    check($sformatf("burst%0d d_rvalid", i), 32'(bus.d_rvalid), 32'(!prev_c));
                end
                prev_c = exp_c;
            end
        end

        // DMA left as owner, one idle cycle, then contention returns to CPU.
        @(negedge clk);
        drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(0, 1, 0, 16'h0040, 16'h0, 1, 0, 16'h0050, 16'h0);
            #1;
            check($sformatf("pre_idle%0d d_gnt", i), 32'(bus.d_gnt), 32'(i >= 4));
        end
        @(negedge clk);
        drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        #1;
        check("idle c_gnt", 32'(bus.c_gnt), 32'(0));
        check("idle d_gnt", 32'(bus.d_gnt), 32'(0));
        @(negedge clk);
        drive(0, 1, 0, 16'h0040, 16'h0, 1, 0, 16'h0050, 16'h0);
        #1;
        check("after_idle c_gnt", 32'(bus.c_gnt), 32'(1));
        check("after_idle d_gnt", 32'(bus.d_gnt), 32'(0));

        @(negedge clk);
        drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mem_port_arbiter

`default_nettype wire
